// File: rtl/cubic_interp_pipe_if.sv
// ---------------------------------------------------------------------------
// cubic_interp_pipe_if
//   Stream bundle for one cubic/linear interpolation engine.
//   Input side : in_valid / in_ready handshake carrying in_mode, in_t,
//                in_p (four packed DW-bit taps, P0 in the LSBs) and in_tag.
//   Output side: out_valid / out_ready handshake carrying out_data, out_tag.
//   Status     : busy, high while any beat is held inside the engine.
//   modport slave  : the engine side (consumes input beats, produces results).
//   modport master : the side that feeds beats and drains results.
// ---------------------------------------------------------------------------
interface cubic_interp_pipe_if #(
  parameter int DW    = 8,
  parameter int FW    = 8,
  parameter int TAG_W = 4
) ();
  logic               in_valid;
  logic               in_ready;
  logic               in_mode;
  logic [FW-1:0]      in_t;
  logic [4*DW-1:0]    in_p;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_data;
  logic [TAG_W-1:0]   out_tag;
  logic               busy;

  modport slave (
    input  in_valid, in_mode, in_t, in_p, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, busy
  );

  modport master (
    output in_valid, in_mode, in_t, in_p, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, busy
  );
endinterface

// File: rtl/cubic_interp_pipe.sv
// ---------------------------------------------------------------------------
// cubic_interp_pipe
//   Fully pipelined 1-D interpolator: one 4-tap group plus fraction t in,
//   one clamped pixel out per beat. Catmull-Rom cubic (mode 0) or linear
//   (mode 1, P1/P2 only), selectable per beat; the tag rides along.
//
//   Pipeline (all stages advance together under a single enable):
//     s1 : capture accepted beat (mode, t, taps, tag)
//     s2 : tap weights, scaled by 2*S^3
//     s3 : per-tap products Wi*Pi
//     s4 : signed accumulation
//     out: round-half-up, clamp, output register
//   A beat taken at edge n is presented on the output after edge n+4.
//
//   Ports:
//     clk   - clock
//     rst_n - synchronous active-low reset; empties the pipeline
//     bus   - cubic_interp_pipe_if.slave stream bundle (see interface file)
// ---------------------------------------------------------------------------
module cubic_interp_pipe #(
  parameter int DW    = 8,
  parameter int FW    = 8,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cubic_interp_pipe_if.slave   bus
);

  // Weight magnitudes reach 2*S^3 = 2^(3*FW+1); a few spare bits keep every
  // intermediate of the cubic polynomials exact.
  localparam int CW = 3 * FW + 6;
  localparam int PW = CW + DW + 1;
  localparam int AW = PW + 2;
  localparam int SH = 3 * FW + 1;

  localparam logic signed [CW-1:0] S_C    = CW'(1) << FW;
  localparam logic signed [CW-1:0] UNITY  = CW'(1) << SH;
  localparam logic signed [AW-1:0] RND    = AW'(1) << (3 * FW);
  localparam logic signed [AW-1:0] MAXV   = (AW'(1) << DW) - AW'(1);

  // Global enable: everything moves only when the output slot can drain.
  logic en;
  logic take;

  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
  logic out_valid_q, out_valid_d;

  logic             mode1_q, mode1_d;
  logic [FW-1:0]    t1_q, t1_d;
  logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
  logic [TAG_W-1:0] tag4_q, tag4_d, out_tag_q, out_tag_d;
  logic [DW-1:0]    out_data_q, out_data_d;

  logic signed [CW-1:0] w_c [4];
  logic signed [PW-1:0] prod_c [4];
  logic signed [AW-1:0] acc4_q, acc4_d;
  logic signed [AW-1:0] r_c;

  assign en   = rst_n & (~out_valid_q | bus.out_ready);
  assign take = en & bus.in_valid;

  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.busy      = v1_q | v2_q | v3_q | v4_q | out_valid_q;

  // ---------------- control / sideband ----------------
  always_comb begin
    v1_d        = bus.in_valid;
    v2_d        = v1_q;
    v3_d        = v2_q;
    v4_d        = v3_q;
    out_valid_d = v4_q;
    mode1_d     = bus.in_mode;
    t1_d        = bus.in_t;
    tag1_d      = bus.in_tag;
    tag2_d      = tag1_q;
    tag3_d      = tag2_q;
    tag4_d      = tag3_q;
    out_tag_d   = tag4_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      v4_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
    end else if (en) begin
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      v3_q        <= v3_d;
      v4_q        <= v4_d;
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
    end
  end

  // Input-side fields are captured only on an accepted beat.
  always_ff @(posedge clk) begin
    if (take) begin
      mode1_q <= mode1_d;
      t1_q    <= t1_d;
      tag1_q  <= tag1_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      tag2_q <= tag2_d;
      tag3_q <= tag3_d;
      tag4_q <= tag4_d;
    end
  end

  // ---------------- weights (from stage-1 registers) ----------------
  always_comb begin
    logic signed [CW-1:0] t_e;
    logic signed [CW-1:0] t2;
    logic signed [CW-1:0] t3;
    t_e = CW'(t1_q);
    t2  = t_e * t_e;
    t3  = t2 * t_e;
    if (mode1_q) begin
      w_c[0] = '0;
      w_c[1] = (S_C - t_e) <<< (2 * FW + 1);
      w_c[2] = t_e <<< (2 * FW + 1);
      w_c[3] = '0;
    end else begin
      // Constant multiples written as shift-adds so every term stays CW wide.
      w_c[0] = (t2 <<< (FW + 1)) - t3 - (t_e <<< (2 * FW));
      w_c[1] = (t3 <<< 1) + t3 - (t2 <<< (FW + 2)) - (t2 <<< FW) + UNITY;
      w_c[2] = (t2 <<< (FW + 2)) + (t_e <<< (2 * FW)) - (t3 <<< 1) - t3;
      w_c[3] = t3 - (t2 <<< FW);
    end
  end

  // ---------------- per-tap datapath ----------------
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_tap
    logic [DW-1:0]        p1_q, p1_d, p2_q, p2_d;
    logic signed [CW-1:0] w2_q, w2_d;
    logic signed [PW-1:0] prod3_q, prod3_d;

    always_comb begin
      p1_d    = bus.in_p[gi*DW +: DW];
      p2_d    = p1_q;
      w2_d    = w_c[gi];
      // Taps are unsigned; zero-extend before the signed multiply.
      prod3_d = PW'(w2_q) * $signed(PW'(p2_q));
    end

    always_ff @(posedge clk) begin
      if (take) begin
        p1_q <= p1_d;
      end
    end

    always_ff @(posedge clk) begin
      if (en) begin
        p2_q    <= p2_d;
        w2_q    <= w2_d;
        prod3_q <= prod3_d;
      end
    end

    assign prod_c[gi] = prod3_q;
  end

  // ---------------- accumulate, round, clamp ----------------
  always_comb begin
    acc4_d = AW'(prod_c[0]) + AW'(prod_c[1]) + AW'(prod_c[2]) + AW'(prod_c[3]);
  end

  always_ff @(posedge clk) begin
    if (en) begin
      acc4_q <= acc4_d;
    end
  end

  always_comb begin
    // Adding half an LSB before the arithmetic shift gives round-half-up,
    // including for negative sums.
    r_c = (acc4_q + RND) >>> SH;
    if (r_c[AW-1]) begin
      out_data_d = '0;
    end else if (r_c > MAXV) begin
      out_data_d = '1;
    end else begin
      out_data_d = r_c[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q <= '0;
    end else if (en) begin
      out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_cubic_interp_pipe.sv
// ---------------------------------------------------------------------------
// tb_cubic_interp_pipe
//   Self-checking bench for cubic_interp_pipe. Expected pixels come from a
//   direct evaluation of the weight polynomials with 64-bit integers; a
//   scoreboard queue holds one expectation per accepted beat and a single
//   compare process checks every output transfer, busy, and hold stability.
//   Directed beats additionally pin results and latency to literal values.
// ---------------------------------------------------------------------------
module tb_cubic_interp_pipe;
  localparam int DW    = 8;
  localparam int FW    = 8;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cubic_interp_pipe_if #(.DW(DW), .FW(FW), .TAG_W(TAG_W)) bus ();

  cubic_interp_pipe #(.DW(DW), .FW(FW), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int data;
    int tag;
  } exp_t;

  exp_t   exp_q[$];
  int     n_cmp  = 0;
  int     n_fail = 0;
  longint cyc    = 0;
  bit     rand_bp = 1'b0;
  bit     hold_prev = 1'b0;
  int     hold_data, hold_tag;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain evaluation of the interpolation formulas.
  function automatic int model(bit m, int t, int p0, int p1, int p2, int p3);
    longint s, tt, w0, w1, w2, w3, acc, r;
    s  = longint'(1) << FW;
    tt = t;
    if (m) begin
      w0 = 0;
      w1 = 2 * s * s * (s - tt);
      w2 = 2 * s * s * tt;
      w3 = 0;
    end else begin
      w0 = -tt*tt*tt + 2*tt*tt*s - tt*s*s;
      w1 = 3*tt*tt*tt - 5*tt*tt*s + 2*s*s*s;
      w2 = -3*tt*tt*tt + 4*tt*tt*s + tt*s*s;
      w3 = tt*tt*tt - tt*tt*s;
    end
    acc = w0*p0 + w1*p1 + w2*p2 + w3*p3;
    r   = (acc + (longint'(1) << (3*FW))) >>> (3*FW + 1);
    if (r < 0) return 0;
    if (r > (1 << DW) - 1) return (1 << DW) - 1;
    return int'(r);
  endfunction

  // Single compare process: every output transfer, busy, and hold stability.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_prev = 1'b0;
      end else begin
        chk("busy", bus.busy, longint'(exp_q.size() != 0));
        if (hold_prev) begin
          chk("hold_valid", bus.out_valid, 1);
          chk("hold_data", bus.out_data, hold_data);
          chk("hold_tag", bus.out_tag, hold_tag);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_out: got tag %0d data %0d, required no output", bus.out_tag, bus.out_data);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", bus.out_data, e.data);
            chk("out_tag", bus.out_tag, e.tag);
          end
        end
        hold_prev = bus.out_valid && !bus.out_ready;
        hold_data = bus.out_data;
        hold_tag  = bus.out_tag;
      end
    end
  end

  // Random backpressure, active only while rand_bp is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Presents one beat until accepted; pushes its expectation afterwards.
  task automatic send_beat(input bit m, input int t, input logic [4*DW-1:0] p, input int tag);
    bit took = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_mode  = m;
    bus.in_t     = t[FW-1:0];
    bus.in_p     = p;
    bus.in_tag   = tag[TAG_W-1:0];
    for (int i = 0; i < 200 && !took; i++) begin
      @(negedge clk);
      took = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (took) begin
      exp_q.push_back('{data: model(m, t, int'(p[DW-1:0]), int'(p[2*DW-1:DW]),
                                    int'(p[3*DW-1:2*DW]), int'(p[4*DW-1:3*DW])),
                        tag: tag});
    end else begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got no in_ready for tag %0d, required acceptance", tag);
    end
  endtask

  // Directed beat with literal expectation and latency measurement.
  task automatic directed(input string name, input bit m, input int t,
                          input int p0, input int p1, input int p2, input int p3,
                          input int tag, input int req);
    logic [4*DW-1:0] p;
    longint n;
    bit seen = 1'b0;
    p = {DW'(p3), DW'(p2), DW'(p1), DW'(p0)};
    send_beat(m, t, p, tag);
    n = cyc;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no out_valid, required one", name);
    end else begin
      chk({name, "_latency"}, cyc - n, 4);
      chk({name, "_data"}, bus.out_data, req);
      chk({name, "_tag"}, bus.out_tag, tag);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && (exp_q.size() != 0 || bus.busy); i++) @(posedge clk);
    #1;
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation timeout, required completion");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.in_t      = '0;
    bus.in_p      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed values
    directed("cub_t0",   0, 0,   10, 20, 30, 40, 3, 20);
    directed("cub_t128", 0, 128, 0, 100, 200, 255, 5, 153);
    directed("cub_flat", 0, 64,  50, 50, 50, 50, 6, 50);
    directed("clamp_hi", 0, 128, 0, 255, 255, 0, 9, 255);
    directed("clamp_lo", 0, 128, 255, 0, 0, 255, 10, 0);
    directed("lin_t64",  1, 64,  $urandom_range(0, 255), 100, 200, $urandom_range(0, 255), 11, 125);
    directed("lin_half", 1, 128, $urandom_range(0, 255), 1, 2, $urandom_range(0, 255), 12, 2);
    drain("directed_drain");

    // Backpressure: tags 0..5 back to back, 3-cycle stall once tag 0 shows.
    fork
      begin : bp_feed
        for (int k = 0; k < 6; k++) send_beat(1'b0, $urandom_range(0, 255), $urandom, k);
      end
      begin : bp_stall
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
          @(posedge clk);
          #2;
          seen = bus.out_valid && (bus.out_tag == 0);
        end
        if (!seen) begin
          n_cmp++;
          n_fail++;
          $display("FAIL bp_tag0_timeout: got no tag 0 output, required one");
        end else begin
          bus.out_ready = 1'b0;
          repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_out_tag", bus.out_tag, 0);
            @(posedge clk);
            #2;
          end
          bus.out_ready = 1'b1;
        end
      end
    join
    drain("bp_all_delivered");

    // Reset mid-stream with three beats in flight.
    send_beat(1'b0, $urandom_range(0, 255), $urandom, 13);
    send_beat(1'b1, $urandom_range(0, 255), $urandom, 14);
    send_beat(1'b0, $urandom_range(0, 255), $urandom, 15);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_out_data", bus.out_data, 0);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    directed("post_rst", 0, 0, 10, 20, 30, 40, 7, 20);
    drain("post_rst_drain");

    // Randomised mixed-mode stream with random gaps and backpressure.
    rand_bp = 1'b1;
    for (int k = 0; k < 300; k++) begin
      send_beat(1'($urandom_range(0, 1)), $urandom_range(0, (1 << FW) - 1), $urandom, $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
